// File: rtl/display_controller_pkg.sv
// Shared types and helpers for the display controller scanout path.
package display_controller_pkg;

    // Width of the data mover address/length bus.
    localparam int unsigned DcAddrWidth = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitCredit
    } scanout_state_e;

    typedef struct packed {
        logic [DcAddrWidth-1:0] src;
        logic [DcAddrWidth-1:0] dst;
        logic [DcAddrWidth-1:0] len;
    } scanout_cmd_t;

    // Clear the low block_size bits so the value is a whole number of blocks.
    function automatic logic [DcAddrWidth-1:0] block_align(
        input logic [DcAddrWidth-1:0] addr,
        input int unsigned            block_size
    );
        logic [DcAddrWidth-1:0] mask;
        mask = ~((DcAddrWidth'(1) << block_size) - DcAddrWidth'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/display_controller_credit_counter.sv
// Saturating up/down credit counter for line-buffer slots.
// Starts full (NumSlots); inc and dec in the same cycle cancel out.
module display_controller_credit_counter #(
    parameter int unsigned NumSlots = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           inc,
    input  logic                           dec,
    output logic [$clog2(NumSlots+1)-1:0]  credit,
    output logic [$clog2(NumSlots+1)-1:0]  credit_next
);

    localparam int unsigned CntWidth = $clog2(NumSlots + 1);
    localparam logic [CntWidth-1:0] Full = CntWidth'(NumSlots);

    logic [CntWidth-1:0] credit_q, credit_d;

    // Next credit: saturate at Full, never go below zero.
    always_comb begin
        credit_d = credit_q;
        if (inc && !dec && (credit_q != Full)) begin
            credit_d = credit_q + CntWidth'(1);
        end else if (dec && !inc && (credit_q != '0)) begin
            credit_d = credit_q - CntWidth'(1);
        end
    end

    // Credit register, full out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= Full;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit      = credit_q;
    assign credit_next = credit_d;

endmodule

// File: rtl/display_controller_scanout_seq.sv
// Frame scanout sequencer: one block-aligned copy command per framebuffer line,
// flow-controlled by line-buffer slot credits.
// Optional build macro DISPLAY_CONTROLLER_SCANOUT_SHADOW_EN latches the frame
// configuration at frame start; without it stride, line bytes, line count and
// dst base are used live.
module display_controller_scanout_seq
    import display_controller_pkg::*;
#(
    parameter int unsigned AddrWidth = DcAddrWidth,
    parameter int unsigned BlockSize = 6,
    parameter int unsigned LineWidth = 12,
    parameter int unsigned NumSlots  = 2,
    parameter int unsigned SlotBytes = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_enable_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_stride_i,
    input  logic [AddrWidth-1:0] cfg_line_bytes_i,
    input  logic [LineWidth-1:0] cfg_lines_i,
    input  logic [AddrWidth-1:0] dst_base_i,
    input  logic                 frame_start_i,
    input  logic                 line_done_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [AddrWidth-1:0] src_o,
    output logic [AddrWidth-1:0] dst_o,
    output logic [AddrWidth-1:0] len_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 underrun_o
);

    localparam int unsigned CreditWidth  = $clog2(NumSlots + 1);
    localparam int unsigned SlotWidth    = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned LineCntWidth = LineWidth + 1;

    scanout_state_e         state_q, state_d;
    scanout_cmd_t           cmd_q, cmd_d;
    logic                   valid_q, valid_d;
    logic [AddrWidth-1:0]   src_q, src_d;
    logic [SlotWidth-1:0]   slot_q, slot_d;
    logic [LineWidth-1:0]   line_q, line_d;
    logic                   busy_q;
    logic                   done_q, done_d;
    logic                   underrun_q, underrun_d;

    logic                   handshake;
    logic                   frame_accept;
    logic                   last_line;
    logic [CreditWidth-1:0] credit;
    logic [CreditWidth-1:0] credit_next;

    logic [AddrWidth-1:0]   act_stride;
    logic [AddrWidth-1:0]   act_line_bytes;
    logic [AddrWidth-1:0]   act_dst_base;
    logic [LineWidth-1:0]   act_lines;

    // Lines too short to hold one block count as an empty frame.
    function automatic logic [LineWidth-1:0] eff_lines(
        input logic [LineWidth-1:0] lines,
        input logic [AddrWidth-1:0] line_bytes
    );
        return ((line_bytes >> BlockSize) == '0) ? '0 : lines;
    endfunction

    function automatic scanout_cmd_t make_cmd(
        input logic [AddrWidth-1:0] src,
        input logic [SlotWidth-1:0] slot,
        input logic [AddrWidth-1:0] dst_base,
        input logic [AddrWidth-1:0] line_bytes
    );
        scanout_cmd_t cmd;
        logic [AddrWidth-1:0] dst;
        dst      = dst_base + AddrWidth'(slot) * AddrWidth'(SlotBytes);
        cmd.src  = block_align(DcAddrWidth'(src), BlockSize);
        cmd.dst  = block_align(DcAddrWidth'(dst), BlockSize);
        cmd.len  = block_align(DcAddrWidth'(line_bytes), BlockSize);
        return cmd;
    endfunction

    // valid_q is high exactly while in StIssue.
    assign handshake    = valid_q && ready_i;
    assign frame_accept = (state_q == StIdle) && frame_start_i && cfg_enable_i;
    assign last_line    = (LineCntWidth'(line_q) + LineCntWidth'(1))
                          >= LineCntWidth'(eff_lines(act_lines, act_line_bytes));

    display_controller_credit_counter #(
        .NumSlots (NumSlots)
    ) u_credit (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc         (line_done_i),
        .dec         (handshake),
        .credit      (credit),
        .credit_next (credit_next)
    );

`ifdef DISPLAY_CONTROLLER_SCANOUT_SHADOW_EN
    logic [AddrWidth-1:0] stride_q, line_bytes_q, dst_base_q;
    logic [LineWidth-1:0] lines_q;

    // Freeze the frame configuration when a frame is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stride_q     <= '0;
            line_bytes_q <= '0;
            dst_base_q   <= '0;
            lines_q      <= '0;
        end else if (frame_accept) begin
            stride_q     <= cfg_stride_i;
            line_bytes_q <= cfg_line_bytes_i;
            dst_base_q   <= dst_base_i;
            lines_q      <= cfg_lines_i;
        end
    end

    assign act_stride     = stride_q;
    assign act_line_bytes = line_bytes_q;
    assign act_dst_base   = dst_base_q;
    assign act_lines      = lines_q;
`else
    assign act_stride     = cfg_stride_i;
    assign act_line_bytes = cfg_line_bytes_i;
    assign act_dst_base   = dst_base_i;
    assign act_lines      = cfg_lines_i;
`endif

    // Sequencer next state; the next command is formed one cycle ahead so
    // the payload leaves straight from registers.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cmd_d      = cmd_q;
        src_d      = src_q;
        slot_d     = slot_q;
        line_d     = line_q;
        done_d     = 1'b0;
        underrun_d = frame_start_i && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (frame_accept) begin
                    src_d  = cfg_base_i;
                    line_d = '0;
                    if (eff_lines(cfg_lines_i, cfg_line_bytes_i) == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cmd_d = make_cmd(cfg_base_i, slot_q, dst_base_i, cfg_line_bytes_i);
                        if (credit_next != '0) begin
                            state_d = StIssue;
                            valid_d = 1'b1;
                        end else begin
                            state_d = StWaitCredit;
                        end
                    end
                end
            end
            StIssue: begin
                if (handshake) begin
                    src_d  = src_q + act_stride;
                    slot_d = (slot_q == SlotWidth'(NumSlots - 1)) ? '0 : slot_q + SlotWidth'(1);
                    line_d = line_q + LineWidth'(1);
                    if (last_line) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (credit_next != '0) begin
                        cmd_d = make_cmd(src_d, slot_d, act_dst_base, act_line_bytes);
                    end else begin
                        state_d = StWaitCredit;
                        valid_d = 1'b0;
                    end
                end
            end
            StWaitCredit: begin
                if (credit_next != '0) begin
                    state_d = StIssue;
                    valid_d = 1'b1;
                    cmd_d   = make_cmd(src_q, slot_q, act_dst_base, act_line_bytes);
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            cmd_q      <= '0;
            src_q      <= '0;
            slot_q     <= '0;
            line_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cmd_q      <= cmd_d;
            src_q      <= src_d;
            slot_q     <= slot_d;
            line_q     <= line_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign valid_o      = valid_q;
    assign src_o        = AddrWidth'(cmd_q.src);
    assign dst_o        = AddrWidth'(cmd_q.dst);
    assign len_o        = AddrWidth'(cmd_q.len);
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign underrun_o   = underrun_q;

endmodule
